// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_pkg                                                                   |
// | Shared types and constants for the instruction fetch stage.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package core_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/core_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_fetch_if                                                              |
// | Instruction memory, execute-redirect and decoder signals of the fetch stage|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface core_fetch_if;

   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        halt_i;
   logic        stall_i;
   logic [31:0] instruction_o;
   logic        instruction_valid_o;
   logic [31:0] program_cnt_o;

   modport master (
      output imem_req_o, imem_addr_o, instruction_o, instruction_valid_o, program_cnt_o,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i,
             halt_i, stall_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, instruction_o, instruction_valid_o, program_cnt_o,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i,
             halt_i, stall_i
   );

endinterface
`default_nettype wire

// File: rtl/core_fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_fetch_fifo                                                            |
// | Synchronous FIFO of fetch entries with flush; head is read combinationally.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module core_fetch_fifo
   import core_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              i_push,
   input  wire fetch_entry_t      i_data,
   input  wire logic              i_pop,
   input  wire logic              i_flush,
   output fetch_entry_t           o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int             c_AW   = $clog2(DEPTH);
   localparam logic [c_AW:0]  c_FULL = (c_AW + 1)'(DEPTH);

   fetch_entry_t    r_mem [DEPTH];
   logic [c_AW-1:0] r_wr;
   logic [c_AW-1:0] r_rd;
   logic [c_AW:0]   r_count;
   logic            w_push;
   logic            w_pop;

   assign w_pop  = i_pop && (r_count != '0);
   assign w_push = i_push && ((r_count != c_FULL) || w_pop);

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: contents are only observed through r_count.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

   assign o_data  = r_mem[r_rd];
   assign o_full  = (r_count == c_FULL);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/core_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_fetch                                                                 |
// | Fetch stage: PC, imem requests, in-order response buffering, redirects.    |
// | Optional CORE_FETCH_PERF_EN adds fetched/bubble performance counters.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module core_fetch
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  wire logic    clk_i,
   input  wire logic    rst_i,
   core_fetch_if.master fetch_if
`ifdef CORE_FETCH_PERF_EN
   ,
   output logic [31:0]  perf_fetched_o,
   output logic [31:0]  perf_bubble_o
`endif
);

   localparam int              c_AW    = $clog2(FIFO_DEPTH);
   localparam int              c_CW    = c_AW + 1;
   localparam int              c_DW    = c_CW + 2;
   localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FIFO_DEPTH);

   fetch_state_e    r_state;
   fetch_state_e    w_state_next;
   logic [31:0]     r_pc;
   logic [c_CW-1:0] r_outstanding;
   logic [c_DW-1:0] r_discard;
   logic [31:0]     r_os_pc [FIFO_DEPTH];
   logic [c_AW-1:0] r_os_wr;
   logic [c_AW-1:0] r_os_rd;

   logic            w_req;
   logic            w_grant;
   logic            w_rsp_live;
   logic            w_rsp_drop;
   logic            w_push;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic [c_CW-1:0] w_count;
   logic [c_DW-1:0] w_discard_redirect;
   fetch_entry_t    w_head;
   fetch_entry_t    w_new;

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= BOOT;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         BOOT:    w_state_next = RUN;
         RUN:     if (fetch_if.halt_i)  w_state_next = HALT;
         HALT:    if (!fetch_if.halt_i) w_state_next = RUN;
         default: w_state_next = BOOT;
      endcase
   end

   // Credit counts live requests plus buffered entries, so every response has a slot.
   assign w_req      = (r_state == RUN) && !fetch_if.redirect_i &&
                       ((r_outstanding + w_count) < c_DEPTH);
   assign w_grant    = w_req && fetch_if.imem_gnt_i;
   assign w_rsp_drop = fetch_if.imem_rvalid_i && (r_discard != '0);
   assign w_rsp_live = fetch_if.imem_rvalid_i && (r_discard == '0) && (r_outstanding != '0);
   assign w_push     = w_rsp_live && !fetch_if.redirect_i && (!w_full || w_pop);
   assign w_pop      = !w_empty && !fetch_if.stall_i;
   assign w_new      = '{pc: r_os_pc[r_os_rd], instr: fetch_if.imem_rdata_i};

   // No grant can coincide with a redirect since the request is suppressed then.
   assign w_discard_redirect = r_discard + c_DW'(r_outstanding) -
                               c_DW'(w_rsp_live || w_rsp_drop);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pc          <= RESET_PC & ~32'h3;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_os_wr       <= '0;
         r_os_rd       <= '0;
      end else if (fetch_if.redirect_i) begin
         r_pc          <= fetch_if.redirect_pc_i & ~32'h3;
         r_outstanding <= '0;
         r_discard     <= w_discard_redirect;
         r_os_wr       <= '0;
         r_os_rd       <= '0;
      end else begin
         if (w_grant) begin
            r_pc    <= r_pc + 32'd4;
            r_os_wr <= r_os_wr + 1'b1;
         end
         if (w_rsp_live) r_os_rd   <= r_os_rd + 1'b1;
         if (w_rsp_drop) r_discard <= r_discard - 1'b1;
         case ({w_grant, w_rsp_live})
            2'b10:   r_outstanding <= r_outstanding + 1'b1;
            2'b01:   r_outstanding <= r_outstanding - 1'b1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_grant) r_os_pc[r_os_wr] <= r_pc;
   end

   core_fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk_i),
      .rst     (rst_i),
      .i_push  (w_push),
      .i_data  (w_new),
      .i_pop   (w_pop),
      .i_flush (fetch_if.redirect_i),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign fetch_if.imem_req_o          = w_req;
   assign fetch_if.imem_addr_o         = r_pc;
   assign fetch_if.instruction_valid_o = !w_empty;
   assign fetch_if.instruction_o       = w_empty ? 32'h0 : w_head.instr;
   assign fetch_if.program_cnt_o       = w_empty ? 32'h0 : w_head.pc;

`ifdef CORE_FETCH_PERF_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_fetched_o <= '0;
         perf_bubble_o  <= '0;
      end else begin
         if (w_pop) perf_fetched_o <= perf_fetched_o + 32'd1;
         if (w_empty && !fetch_if.stall_i && (r_state == RUN))
            perf_bubble_o <= perf_bubble_o + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_core_fetch                                                              |
// | Cycle vector table plus a streaming run against a one-cycle memory.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_core_fetch;
   import core_pkg::*;

   typedef struct {
      logic        rst;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        redir;
      logic [31:0] rpc;
      logic        halt;
      logic        stall;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   core_fetch_if fif ();

`ifdef CORE_FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_bubble;
`endif

   core_fetch #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) u_dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .fetch_if (fif.master)
`ifdef CORE_FETCH_PERF_EN
      ,
      .perf_fetched_o (perf_fetched),
      .perf_bubble_o  (perf_bubble)
`endif
   );

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return 32'h1000_0000 | a;
   endfunction

   function automatic vec_t mk(input logic r, input logic g, input logic v,
                               input logic [31:0] v_addr, input logic rd,
                               input logic [31:0] rpc, input logic h, input logic s,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, input logic [31:0] e_pc);
      vec_t t;
      t.rst     = r;
      t.gnt     = g;
      t.rv      = v;
      t.rdata   = instr_of(v_addr);
      t.redir   = rd;
      t.rpc     = rpc;
      t.halt    = h;
      t.stall   = s;
      t.e_req   = e_req;
      t.e_addr  = e_addr;
      t.e_valid = e_valid;
      t.e_pc    = e_valid ? e_pc : 32'h0;
      t.e_instr = e_valid ? instr_of(e_pc) : 32'h0;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic apply(input vec_t t);
      rst               = t.rst;
      fif.imem_gnt_i    = t.gnt;
      fif.imem_rvalid_i = t.rv;
      fif.imem_rdata_i  = t.rdata;
      fif.redirect_i    = t.redir;
      fif.redirect_pc_i = t.rpc;
      fif.halt_i        = t.halt;
      fif.stall_i       = t.stall;
   endtask

   initial begin
      vec_t vecs[$];
      apply(mk(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);

      //               rst gnt rv  rvaddr     rd rpc         h  s   req addr       vld pc
      vecs.push_back(mk(0, 1, 0, 32'h000, 0, 32'h000, 0, 0,  0, 32'h000, 0, 32'h000)); // BOOT
      vecs.push_back(mk(0, 1, 0, 32'h000, 0, 32'h000, 0, 0,  1, 32'h000, 0, 32'h000));
      vecs.push_back(mk(0, 1, 1, 32'h000, 0, 32'h000, 0, 0,  1, 32'h004, 0, 32'h000));
      vecs.push_back(mk(0, 1, 1, 32'h004, 0, 32'h000, 0, 0,  0, 32'h008, 1, 32'h000));
      vecs.push_back(mk(0, 1, 0, 32'h000, 0, 32'h000, 0, 0,  1, 32'h008, 1, 32'h004));
      vecs.push_back(mk(0, 1, 1, 32'h008, 0, 32'h000, 0, 0,  1, 32'h00C, 0, 32'h000));
      vecs.push_back(mk(0, 1, 1, 32'h00C, 0, 32'h000, 0, 1,  0, 32'h010, 1, 32'h008)); // stall
      vecs.push_back(mk(0, 1, 0, 32'h000, 0, 32'h000, 0, 1,  0, 32'h010, 1, 32'h008));
      vecs.push_back(mk(0, 1, 0, 32'h000, 0, 32'h000, 0, 1,  0, 32'h010, 1, 32'h008));
      vecs.push_back(mk(0, 1, 0, 32'h000, 0, 32'h000, 0, 0,  0, 32'h010, 1, 32'h008));
      vecs.push_back(mk(0, 0, 0, 32'h000, 0, 32'h000, 0, 0,  1, 32'h010, 1, 32'h00C)); // gnt held
      vecs.push_back(mk(0, 0, 0, 32'h000, 0, 32'h000, 0, 0,  1, 32'h010, 0, 32'h000));
      vecs.push_back(mk(0, 0, 0, 32'h000, 0, 32'h000, 0, 0,  1, 32'h010, 0, 32'h000));
      vecs.push_back(mk(0, 1, 0, 32'h000, 0, 32'h000, 0, 0,  1, 32'h010, 0, 32'h000));
      vecs.push_back(mk(0, 1, 0, 32'h000, 0, 32'h000, 0, 0,  1, 32'h014, 0, 32'h000));
      vecs.push_back(mk(0, 1, 1, 32'h010, 1, 32'h103, 0, 0,  0, 32'h018, 0, 32'h000)); // redirect
      vecs.push_back(mk(0, 1, 1, 32'h014, 0, 32'h000, 0, 0,  1, 32'h100, 0, 32'h000));
      vecs.push_back(mk(0, 0, 1, 32'h100, 0, 32'h000, 0, 0,  1, 32'h104, 0, 32'h000));
      vecs.push_back(mk(0, 0, 0, 32'h000, 0, 32'h000, 1, 0,  1, 32'h104, 1, 32'h100)); // halt
      vecs.push_back(mk(0, 1, 0, 32'h000, 0, 32'h000, 1, 0,  0, 32'h104, 0, 32'h000));
      vecs.push_back(mk(0, 1, 0, 32'h000, 0, 32'h000, 0, 0,  0, 32'h104, 0, 32'h000));
      vecs.push_back(mk(0, 1, 0, 32'h000, 0, 32'h000, 0, 0,  1, 32'h104, 0, 32'h000));
      vecs.push_back(mk(1, 1, 0, 32'h000, 0, 32'h000, 0, 0,  1, 32'h108, 0, 32'h000)); // reset
      vecs.push_back(mk(0, 1, 0, 32'h000, 0, 32'h000, 0, 0,  0, 32'h000, 0, 32'h000));
      vecs.push_back(mk(0, 1, 0, 32'h000, 0, 32'h000, 0, 0,  1, 32'h000, 0, 32'h000));
      vecs.push_back(mk(0, 0, 1, 32'h000, 0, 32'h000, 0, 0,  1, 32'h004, 0, 32'h000));
      vecs.push_back(mk(1, 0, 0, 32'h000, 0, 32'h000, 0, 1,  1, 32'h004, 1, 32'h000)); // reset w/ data
      vecs.push_back(mk(0, 0, 0, 32'h000, 0, 32'h000, 0, 0,  0, 32'h000, 0, 32'h000));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         apply(vecs[i]);
         #1;
         chk($sformatf("row%0d req", i),   32'(fif.imem_req_o),          32'(vecs[i].e_req));
         chk($sformatf("row%0d addr", i),  fif.imem_addr_o,              vecs[i].e_addr);
         chk($sformatf("row%0d valid", i), 32'(fif.instruction_valid_o), 32'(vecs[i].e_valid));
         chk($sformatf("row%0d pc", i),    fif.program_cnt_o,            vecs[i].e_pc);
         chk($sformatf("row%0d instr", i), fif.instruction_o,            vecs[i].e_instr);
      end

      // Streaming against a memory that answers every grant on the next cycle.
      begin : b_stream
         logic        pend;
         logic [31:0] pend_addr;
         logic [31:0] exp_pc;
         int          got;
         pend      = 1'b0;
         pend_addr = 32'h0;
         exp_pc    = 32'h0;
         got       = 0;
         for (int c = 0; c < 60 && got < 6; c++) begin
            @(negedge clk);
            rst               = 1'b0;
            fif.redirect_i    = 1'b0;
            fif.halt_i        = 1'b0;
            fif.imem_gnt_i    = 1'b1;
            fif.imem_rvalid_i = pend;
            fif.imem_rdata_i  = instr_of(pend_addr);
            fif.stall_i       = (c % 3 == 1);
            #1;
            if (fif.instruction_valid_o && !fif.stall_i) begin
               chk($sformatf("stream%0d pc", got),    fif.program_cnt_o, exp_pc);
               chk($sformatf("stream%0d instr", got), fif.instruction_o, instr_of(exp_pc));
               exp_pc = exp_pc + 32'd4;
               got++;
            end
            pend      = fif.imem_req_o && fif.imem_gnt_i;
            pend_addr = fif.imem_addr_o;
         end
         chk("stream delivered", 32'(got), 32'd6);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
